// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic/arithmetic/shift ops plus an optional
// shift-add multiplier enabled by the MC_ALU_MUL_EN macro; registered {C,N,Z} flags.
module mc_alu #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_op,
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  input  logic [1:0]         carry_sel,
  input  logic               flag_regsel,
  input  logic               flagreg_enable,
  input  logic [2:0]         pop_flags,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic [WIDTH-1:0]   result_hi,
  output logic [2:0]         flags,
  output logic [1:0]         dbg_state
);

  // Handshake: a request is taken on a rising edge where in_valid && in_ready;
  // in_valid while in_ready is low is dropped. out_valid is a one-cycle pulse.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state;
  logic   accept;

  assign in_ready  = (state != MUL_RUN);
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  logic [WIDTH:0]       ext;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c;
  logic [SHAMT_W-1:0]   shamt;

  assign shamt = op2[SHAMT_W-1:0];

  // One extra bit on every add/sub/shift captures carry, borrow or the shifted-out bit.
  always_comb begin
    ext     = '0;
    alu_res = op2;
    alu_c   = 1'b0;
    case (alu_op)
      4'd0: alu_res = ~op1;
      4'd1: begin
        ext     = {1'b0, op1} + {{WIDTH{1'b0}}, 1'b1};
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
      end
      4'd2: begin
        ext     = {1'b0, op1} - {{WIDTH{1'b0}}, 1'b1};
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
      end
      4'd3: begin
        ext     = {1'b0, op1} + {1'b0, op2};
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
      end
      4'd4: begin
        ext     = {1'b0, op2} - {1'b0, op1};
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
      end
      4'd5: alu_res = op1 & op2;
      4'd6: alu_res = op1 | op2;
      4'd7: begin
        ext     = {1'b0, op1} << shamt;
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
      end
      4'd8: begin
        ext     = {op1, 1'b0} >> shamt;
        alu_res = ext[WIDTH:1];
        alu_c   = ext[0];
      end
      default: alu_res = op2;
    endcase
  end

  function automatic logic [2:0] next_flags(
    input logic [1:0] cs,
    input logic       frs,
    input logic [2:0] pop,
    input logic       c,
    input logic       n,
    input logic       z,
    input logic       old_c
  );
    logic c_sel;
    if (frs) return pop;
    case (cs)
      2'b00:   c_sel = c;
      2'b01:   c_sel = 1'b1;
      2'b10:   c_sel = 1'b0;
      default: c_sel = old_c;
    endcase
    return {c_sel, n, z};
  endfunction

`ifdef MC_ALU_MUL_EN
  logic                 is_mul;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   prod_next;
  logic [WIDTH:0]       mul_sum;
  logic [SHAMT_W-1:0]   bit_cnt;
  logic [1:0]           cs_q;
  logic                 frs_q;
  logic                 fen_q;
  logic [2:0]           pop_q;

  assign is_mul = (alu_op == 4'd9);

  // Upper half accumulates; lower half holds the remaining multiplier bits.
  assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_next = {mul_sum, prod[WIDTH-1:1]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flags     <= 3'b000;
`ifdef MC_ALU_MUL_EN
      mcand     <= '0;
      prod      <= '0;
      bit_cnt   <= '0;
      cs_q      <= 2'b00;
      frs_q     <= 1'b0;
      fen_q     <= 1'b0;
      pop_q     <= 3'b000;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
`ifdef MC_ALU_MUL_EN
            if (is_mul) begin
              mcand     <= op1;
              prod      <= {{WIDTH{1'b0}}, op2};
              bit_cnt   <= '0;
              cs_q      <= carry_sel;
              frs_q     <= flag_regsel;
              fen_q     <= flagreg_enable;
              pop_q     <= pop_flags;
              out_valid <= 1'b0;
              state     <= MUL_RUN;
            end else
`endif
            begin
              result    <= alu_res;
              result_hi <= '0;
              if (flagreg_enable)
                flags <= next_flags(carry_sel, flag_regsel, pop_flags, alu_c,
                                    alu_res[WIDTH-1], (alu_res == '0), flags[2]);
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end else begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
`ifdef MC_ALU_MUL_EN
        MUL_RUN: begin
          prod    <= prod_next;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == SHAMT_W'(WIDTH - 1)) begin
            result    <= prod_next[WIDTH-1:0];
            result_hi <= prod_next[2*WIDTH-1:WIDTH];
            // The multiplier produces no carry of its own.
            if (fen_q)
              flags <= next_flags(cs_q, frs_q, pop_q, 1'b0,
                                  prod_next[2*WIDTH-1], (prod_next == '0), flags[2]);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
`endif
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits (>=8, power of two).
REQ-002 Parameter: SHAMT_W, $clog2(WIDTH), width of the shift-amount field taken from op2.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: in_valid  input  1  request valid.
REQ-006 Port: in_ready  output  1  block can accept a request this cycle.
REQ-007 Port: alu_op  input  4  opcode: 0 NOT, 1 INC, 2 DEC, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 SHL, 8 SHR, 9 MUL, others MOV.
REQ-008 Port: op1, op2  input  WIDTH each  operands, already forwarded/selected upstream.
REQ-009 Port: carry_sel  input  2  carry source: 00 ALU, 01 force 1, 10 force 0, 11 hold previous C.
REQ-010 Port: flag_regsel  input  1  0 = flags from ALU, 1 = flags from pop_flags.
REQ-011 Port: flagreg_enable  input  1  permit flag register update for this request.
REQ-012 Port: pop_flags  input  3  {C,N,Z} restored from stack.
REQ-013 Port: out_valid  output  1  one-cycle pulse, result/result_hi valid.
REQ-014 Port: result, result_hi  output  WIDTH each  result; result_hi = MUL upper half, else 0.
REQ-015 Port: flags  output  3  registered {C,N,Z}.

Function
REQ-016 Request accepted on rising edge with in_valid && in_ready; in_valid while in_ready=0 SHALL be ignored (no queuing).
REQ-017 FSM states IDLE, MUL_RUN, DONE; in_ready=1 only in IDLE and DONE.
REQ-018 Non-MUL opcodes: IDLE/DONE -> DONE; result registered; out_valid high exactly one cycle after acceptance (latency 1).
REQ-019 DONE with no new acceptance -> IDLE; back-to-back single-cycle requests SHALL sustain one result per cycle.
REQ-020 MUL: unsigned shift-add, one multiplier bit per cycle; IDLE/DONE -> MUL_RUN for WIDTH cycles -> DONE; out_valid WIDTH+1 cycles after acceptance; {result_hi,result} = op1*op2.
REQ-021 Arithmetic modulo 2^WIDTH; ALU carry = bit WIDTH of INC/ADD (op1+op2), borrow of DEC/SUB (SUB = op2-op1); NOT/AND/OR/MOV carry 0.
REQ-022 SHL/SHR by s = op2[SHAMT_W-1:0]; carry = last bit shifted out (SHL op1[WIDTH-s], SHR op1[s-1]); s=0 -> result=op1, carry 0.
REQ-023 N = result[WIDTH-1] (MUL: result_hi[WIDTH-1]); Z = result==0 (MUL: full 2*WIDTH product == 0).
REQ-024 Flags register SHALL update only on the out_valid edge of a request accepted with flagreg_enable=1; otherwise hold.
REQ-025 flag_regsel=1: flags load pop_flags unmodified, carry_sel ignored; result still computed.
REQ-026 carry_sel=11 SHALL keep C from the flags register while N,Z update.
REQ-027 Opcodes 10-15 behave as MOV (result=op2, latency 1).

Reset
REQ-028 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, result=0, result_hi=0, flags=000, regardless of clock.
REQ-029 Reset during MUL_RUN SHALL abort the multiply with no out_valid and no flag update; first edge after release accepts new requests.

Configuration
REQ-030 Macro MC_ALU_MUL_EN: defined -> MUL datapath and MUL_RUN state present per REQ-020.
REQ-031 MC_ALU_MUL_EN undefined -> opcode 9 behaves as MOV (latency 1), result_hi constant 0, MUL_RUN unreachable/absent.

Verification (WIDTH=16)
REQ-032 ADD op1=FFFF op2=0001 carry_sel=00 flagreg_enable=1 -> next cycle result=0000, out_valid=1, flags C=1 N=0 Z=1.
REQ-033 SHL op1=8001 op2=0001 -> result=0002, C=1; SHR op1=0003 op2=0000 -> result=0003, C=0.
REQ-034 MUL op1=FFFF op2=0002 (MUL_EN) -> in_ready=0 16 cycles, out_valid at cycle 17, result_hi=0001 result=FFFE, flags N=0 Z=0; in_valid during busy ignored.
REQ-035 MUL accepted, rst_n pulsed low at cycle 8 -> no out_valid, flags=000, in_ready=1 immediately.
REQ-036 SUB op1=0005 op2=0003 flag_regsel=1 pop_flags=101 -> result=FFFE, flags=101; same with flagreg_enable=0 -> flags unchanged.
REQ-037 Three back-to-back ADDs on consecutive cycles -> three consecutive out_valid pulses with correct results.
